// File: rtl/ddr_init_sequencer.sv
// DDR SDRAM power-up init sequencer (ddr_clk_0 domain).
// Define DDR_INIT_RELOCK_EN to rerun the sequence when clk_ok drops after DONE.
module ddr_init_sequencer #(
    parameter int unsigned POWERUP_CYCLES = 20000,
    parameter int unsigned TRP_CYCLES     = 2,
    parameter int unsigned TMRD_CYCLES    = 2,
    parameter int unsigned TRFC_CYCLES    = 8,
    parameter int unsigned DLL_CYCLES     = 200,
    parameter logic [12:0] EMRS_VALUE     = 13'h0000,
    parameter logic [12:0] MRS_VALUE      = 13'h0022
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_ok,
    output logic        cke,
    output logic        cs_n,
    output logic        ras_n,
    output logic        cas_n,
    output logic        we_n,
    output logic [1:0]  ba,
    output logic [12:0] addr,
    output logic        init_done
);

    function automatic int unsigned at_least_one(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned PU   = at_least_one(POWERUP_CYCLES);
    localparam int unsigned TRP  = at_least_one(TRP_CYCLES);
    localparam int unsigned TMRD = at_least_one(TMRD_CYCLES);
    localparam int unsigned TRFC = at_least_one(TRFC_CYCLES);
    localparam int unsigned TDLL = at_least_one(DLL_CYCLES);
    localparam int unsigned MAXV =
        umax(umax(umax(PU, TRP), umax(TMRD, TRFC)), TDLL);
    localparam int CW = $clog2(MAXV + 1);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_DES  = 4'b1111;

    typedef enum logic [3:0] {
        S_WAIT_LOCK,
        S_POWERUP,
        S_CKE_ON,
        S_PRE1,
        S_EMRS,
        S_MRS_DLLRST,
        S_PRE2,
        S_AREF1,
        S_AREF2,
        S_MRS,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ok_m, ok_s;
    logic          tick, enter, lock_loss;
    logic          cke_d, done_d;
    logic [3:0]    cmd_d;
    logic [1:0]    ba_d;
    logic [12:0]   addr_d;

    // Counter holds the remaining cycles of the current state minus one.
    function automatic logic [CW-1:0] load_val(input state_t s);
        case (s)
            S_POWERUP:            load_val = CW'(PU - 1);
            S_PRE1, S_PRE2:       load_val = CW'(TRP - 1);
            S_EMRS, S_MRS_DLLRST: load_val = CW'(TMRD - 1);
            S_AREF1, S_AREF2:     load_val = CW'(TRFC - 1);
            S_MRS:                load_val = CW'(TDLL - 1);
            default:              load_val = '0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ok_m <= 1'b0;
            ok_s <= 1'b0;
        end else begin
            ok_m <= clk_ok;
            ok_s <= ok_m;
        end
    end

    assign tick = (cnt_q == '0);

`ifdef DDR_INIT_RELOCK_EN
    assign lock_loss = !ok_s;
`else
    assign lock_loss = !ok_s && (state_q != S_DONE);
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_WAIT_LOCK:  if (ok_s) state_d = S_POWERUP;
            S_POWERUP:    if (tick) state_d = S_CKE_ON;
            S_CKE_ON:     if (tick) state_d = S_PRE1;
            S_PRE1:       if (tick) state_d = S_EMRS;
            S_EMRS:       if (tick) state_d = S_MRS_DLLRST;
            S_MRS_DLLRST: if (tick) state_d = S_PRE2;
            S_PRE2:       if (tick) state_d = S_AREF1;
            S_AREF1:      if (tick) state_d = S_AREF2;
            S_AREF2:      if (tick) state_d = S_MRS;
            S_MRS:        if (tick) state_d = S_DONE;
            S_DONE:       state_d = S_DONE;
            default:      state_d = S_WAIT_LOCK;
        endcase
        if (lock_loss) state_d = S_WAIT_LOCK;
    end

    assign enter = (state_d != state_q);

    always_comb begin
        if (state_d == S_WAIT_LOCK || state_d == S_DONE)
            cnt_d = '0;
        else if (enter)
            cnt_d = load_val(state_d);
        else if (!tick)
            cnt_d = cnt_q - CW'(1);
        else
            cnt_d = cnt_q;
    end

    // Outputs are decoded from the next state so they line up with it.
    always_comb begin
        cke_d  = 1'b1;
        cmd_d  = CMD_NOP;
        ba_d   = 2'b00;
        addr_d = 13'h0000;
        done_d = 1'b0;
        unique case (state_d)
            S_WAIT_LOCK, S_POWERUP: begin
                cke_d = 1'b0;
                cmd_d = CMD_DES;
            end
            S_PRE1, S_PRE2: if (enter) begin
                cmd_d  = CMD_PRE;
                addr_d = 13'h0400;
            end
            S_EMRS: if (enter) begin
                cmd_d  = CMD_MRS;
                ba_d   = 2'b01;
                addr_d = EMRS_VALUE;
            end
            S_MRS_DLLRST: if (enter) begin
                cmd_d  = CMD_MRS;
                addr_d = MRS_VALUE | 13'h0100;
            end
            S_AREF1, S_AREF2: if (enter) cmd_d = CMD_AREF;
            S_MRS: if (enter) begin
                cmd_d  = CMD_MRS;
                addr_d = MRS_VALUE;
            end
            S_DONE:   done_d = 1'b1;
            default:  cke_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_WAIT_LOCK;
            cnt_q     <= '0;
            cke       <= 1'b0;
            {cs_n, ras_n, cas_n, we_n} <= CMD_DES;
            ba        <= 2'b00;
            addr      <= 13'h0000;
            init_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cke       <= cke_d;
            {cs_n, ras_n, cas_n, we_n} <= cmd_d;
            ba        <= ba_d;
            addr      <= addr_d;
            init_done <= done_d;
        end
    end

endmodule
